// File: rtl/csh_sweep_ctl.sv
// Full-cache sweep sequencer: walks every line/way pair, looks up its status
// and issues writeback and/or valid-clear operations as selected by func.
module csh_sweep_ctl #(
    parameter int LINES = 128,
    parameter int WAYS  = 4,
    parameter int CNTW  = 10
) (
    input  logic                       clk,
    input  logic                       CROBAR,
    input  logic                       start,
    input  logic [1:0]                 func,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(LINES)-1:0]   line_adr,
    output logic [$clog2(WAYS)-1:0]    way,
    output logic                       look_req,
    input  logic                       look_ack,
    input  logic                       st_valid,
    input  logic                       st_written,
    output logic                       wb_req,
    input  logic                       wb_ack,
    output logic                       clr_val,
    output logic [CNTW-1:0]            wb_count
);

    localparam int LW = $clog2(LINES);
    localparam int WW = $clog2(WAYS);

    localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);
    localparam logic [WW-1:0] WAY_LAST  = WW'(WAYS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOK,
        DECIDE,
        WB,
        CLR,
        NEXT,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [1:0] func_q;
    logic       valid_q;
    logic       written_q;
    logic       abort_pend;
    logic       last_way;
    logic       last_line;
    logic       sweep_go;

    assign last_way  = (way == WAY_LAST);
    assign last_line = (line_adr == LINE_LAST);
    // abort beats start when both arrive together in IDLE
    assign sweep_go  = start && !abort;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        look_req  = 1'b0;
        wb_req    = 1'b0;
        clr_val   = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (sweep_go) begin
                    state_nxt = LOOK;
                end
            end

            LOOK: begin
                look_req = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (look_ack) begin
                    state_nxt = DECIDE;
                end
            end

            DECIDE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (func_q[1] && valid_q && written_q) begin
                    state_nxt = WB;
                end else if (func_q[0] && valid_q) begin
                    state_nxt = CLR;
                end else begin
                    state_nxt = NEXT;
                end
            end

            // An abort seen during the writeback only takes effect once the
            // writeback has been acknowledged.
            WB: begin
                wb_req = 1'b1;
                if (wb_ack) begin
                    if (abort || abort_pend) begin
                        state_nxt = IDLE;
                    end else if (func_q[0]) begin
                        state_nxt = CLR;
                    end else begin
                        state_nxt = NEXT;
                    end
                end
            end

            CLR: begin
                clr_val   = 1'b1;
                state_nxt = abort ? IDLE : NEXT;
            end

            NEXT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last_way && last_line) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = LOOK;
                end
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            func_q     <= 2'b00;
            valid_q    <= 1'b0;
            written_q  <= 1'b0;
            abort_pend <= 1'b0;
            line_adr   <= '0;
            way        <= '0;
            wb_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    if (sweep_go) begin
                        func_q   <= func;
                        line_adr <= '0;
                        way      <= '0;
                        wb_count <= '0;
                    end
                end

                LOOK: begin
                    if (look_ack) begin
                        valid_q   <= st_valid;
                        written_q <= st_written;
                    end
                end

                WB: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (wb_ack) begin
                        wb_count   <= wb_count + CNTW'(1);
                        abort_pend <= 1'b0;
                    end
                end

                // The final entry leaves line_adr/way on LINES-1/WAYS-1.
                NEXT: begin
                    if (!abort && !(last_way && last_line)) begin
                        if (last_way) begin
                            way      <= '0;
                            line_adr <= line_adr + LW'(1);
                        end else begin
                            way      <= way + WW'(1);
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csh_sweep_ctl.sv
// Self-checking bench for csh_sweep_ctl: table-driven full sweeps with a
// directory/writeback responder and a scoreboard of expected clr/wb events.
module tb_csh_sweep_ctl;

    localparam int LINES = 128;
    localparam int WAYS  = 4;
    localparam int CNTW  = 10;
    localparam int LW    = $clog2(LINES);
    localparam int WW    = $clog2(WAYS);

    logic            clk = 1'b0;
    logic            crobar;
    logic            start;
    logic [1:0]      func;
    logic            abort;
    logic            busy;
    logic            done;
    logic [LW-1:0]   line_adr;
    logic [WW-1:0]   way;
    logic            look_req;
    logic            look_ack;
    logic            st_valid;
    logic            st_written;
    logic            wb_req;
    logic            wb_ack;
    logic            clr_val;
    logic [CNTW-1:0] wb_count;

    always #5 clk = ~clk;

    csh_sweep_ctl #(
        .LINES(LINES),
        .WAYS (WAYS),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .CROBAR    (crobar),
        .start     (start),
        .func      (func),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .line_adr  (line_adr),
        .way       (way),
        .look_req  (look_req),
        .look_ack  (look_ack),
        .st_valid  (st_valid),
        .st_written(st_written),
        .wb_req    (wb_req),
        .wb_ack    (wb_ack),
        .clr_val   (clr_val),
        .wb_count  (wb_count)
    );

    typedef struct {
        int l;
        int w;
    } ev_t;

    typedef struct {
        logic [1:0] f;
        int         pat;
        int         dly;
        int         done_cyc;
        int         n_wb;
        int         n_clr;
        bit         poke;
    } row_t;

    int  n_checks = 0;
    int  n_fail   = 0;
    ev_t clr_q[$];
    ev_t wb_q[$];

    // Monitor/responder bookkeeping
    int  cyc      = 0;
    int  t0       = 0;
    int  done_cnt = 0;
    int  done_at  = 0;
    int  clr_cnt  = 0;
    int  wb_cnt   = 0;
    int  wb_cyc   = 0;
    int  wb_run   = 0;
    int  cur_pat  = 0;
    int  wb_dly   = 1;
    bit  look_en  = 1'b1;
    bit  stray_look = 1'b0;
    bit  stray_wb   = 1'b0;

    row_t rows[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Directory contents for each test pattern
    function automatic void get_pat(input int p, input int l, input int w,
                                    output bit v, output bit wr);
        case (p)
            0: begin v = 1'b1; wr = 1'b1; end
            1: begin v = 1'b1; wr = 1'b0; end
            2: begin v = (l == 5 && w == 2); wr = v; end
            3: begin v = (l == 3); wr = v; end
            4: begin v = ((l + w) % 2 == 0); wr = (l % 4 == 0); end
            default: begin v = 1'b0; wr = 1'b0; end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_score();
        clr_q.delete();
        wb_q.delete();
        clr_cnt  = 0;
        wb_cnt   = 0;
        wb_cyc   = 0;
        done_cnt = 0;
    endtask

    // Responder and monitor, both on the falling edge, away from DUT updates.
    initial begin
        bit  v;
        bit  wr;
        ev_t e;
        look_ack   = 1'b0;
        wb_ack     = 1'b0;
        st_valid   = 1'b0;
        st_written = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            get_pat(cur_pat, int'(line_adr), int'(way), v, wr);
            st_valid   = v;
            st_written = wr;
            look_ack   = (look_req && look_en) || stray_look;
            if (wb_req) wb_run++;
            else        wb_run = 0;
            wb_ack = (wb_req && wb_run >= wb_dly) || stray_wb;

            if (start && !busy) t0 = cyc;
            if (wb_req) wb_cyc++;
            if (clr_val) begin
                clr_cnt++;
                if (clr_q.size() == 0) begin
                    check("clr_unexpected", 1, 0);
                end else begin
                    e = clr_q.pop_front();
                    check("clr_line", int'(line_adr), e.l);
                    check("clr_way", int'(way), e.w);
                end
            end
            if (wb_req && wb_ack) begin
                wb_cnt++;
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", 1, 0);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_line", int'(line_adr), e.l);
                    check("wb_way", int'(way), e.w);
                end
            end
            if (done) begin
                done_cnt++;
                done_at = cyc - t0;
                check("done_with_busy", int'(busy), 1);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     int'(busy), 0);
        check({tag, "_done"},     int'(done), 0);
        check({tag, "_look_req"}, int'(look_req), 0);
        check({tag, "_wb_req"},   int'(wb_req), 0);
        check({tag, "_clr_val"},  int'(clr_val), 0);
        check({tag, "_line_adr"}, int'(line_adr), 0);
        check({tag, "_way"},      int'(way), 0);
        check({tag, "_wb_count"}, int'(wb_count), 0);
    endtask

    task automatic run_row(input row_t r);
        bit v;
        bit wr;
        cur_pat = r.pat;
        wb_dly  = r.dly;
        clear_score();
        for (int l = 0; l < LINES; l++) begin
            for (int w = 0; w < WAYS; w++) begin
                get_pat(r.pat, l, w, v, wr);
                if (r.f[1] && v && wr) wb_q.push_back('{l, w});
                if (r.f[0] && v)       clr_q.push_back('{l, w});
            end
        end
        func  = r.f;
        start = 1'b1;
        tick();
        start = 1'b0;
        func  = ~r.f;
        for (int i = 0; i < 6000; i++) begin
            if (done_cnt > 0) break;
            if (r.poke && i == 100) begin
                start = 1'b1; stray_look = 1'b1; stray_wb = 1'b1;
            end else begin
                start = 1'b0; stray_look = 1'b0; stray_wb = 1'b0;
            end
            tick();
        end
        start = 1'b0; stray_look = 1'b0; stray_wb = 1'b0;
        check("done_seen", int'(done_cnt > 0), 1);
        check("done_cycle", done_at, r.done_cyc);
        tick();
        tick();
        check("done_pulses", done_cnt, 1);
        check("idle_busy", int'(busy), 0);
        check("wb_count", int'(wb_count), r.n_wb);
        check("clr_pulses", clr_cnt, r.n_clr);
        check("wb_acks", wb_cnt, r.n_wb);
        check("wb_req_cycles", wb_cyc, r.n_wb * r.dly);
        check("final_line", int'(line_adr), LINES - 1);
        check("final_way", int'(way), WAYS - 1);
        check("clr_q_left", clr_q.size(), 0);
        check("wb_q_left", wb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        crobar = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        func   = 2'b00;

        //         func   pat dly done  wb   clr  poke
        rows[0] = '{2'b00, 0, 1, 1537,   0,   0, 1'b0};
        rows[1] = '{2'b01, 1, 1, 2049,   0, 512, 1'b1};
        rows[2] = '{2'b11, 2, 7, 1545,   1,   1, 1'b0};
        rows[3] = '{2'b10, 1, 1, 1537,   0,   0, 1'b0};
        rows[4] = '{2'b11, 4, 1, 1857,  64, 256, 1'b0};
        rows[5] = '{2'b10, 0, 1, 2049, 512,   0, 1'b0};

        tick();
        tick();
        check_all_zero("reset");
        crobar = 1'b0;
        tick();

        // Stray look_ack in IDLE
        stray_look = 1'b1;
        tick();
        stray_look = 1'b0;
        tick();
        check("stray_ack_busy", int'(busy), 0);
        check("stray_ack_look_req", int'(look_req), 0);

        // start and abort together in IDLE
        clear_score();
        func  = 2'b01;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", int'(busy), 0);
        check("start_abort_look_req", int'(look_req), 0);
        tick();
        check("start_abort_busy2", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_row(rows[i]);
        end

        // wb_count holds in IDLE and is cleared by reset
        tick();
        check("wb_count_hold", int'(wb_count), 512);
        crobar = 1'b1;
        tick();
        crobar = 1'b0;
        check_all_zero("idle_reset");

        // Abort during a delayed writeback at line 3
        cur_pat = 3;
        wb_dly  = 4;
        clear_score();
        wb_q.push_back('{3, 0});
        func  = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        hit   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wb_req) begin hit = 1'b1; break; end
            tick();
        end
        check("abort_wb_reached", int'(hit), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!wb_req) break;
            tick();
        end
        check("abort_busy", int'(busy), 0);
        check("abort_wb_cycles", wb_cyc, 4);
        check("abort_wb_count", int'(wb_count), 1);
        check("abort_wb_acks", wb_cnt, 1);
        check("abort_line", int'(line_adr), 3);
        check("abort_way", int'(way), 0);
        tick();
        tick();
        tick();
        check("abort_no_done", done_cnt, 0);
        check("abort_no_clr", clr_cnt, 0);
        check("abort_busy_later", int'(busy), 0);

        // CROBAR while look_req is held mid-sweep
        cur_pat = 0;
        wb_dly  = 1;
        clear_score();
        look_en = 1'b1;
        func    = 2'b00;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        look_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (look_req) break;
            tick();
        end
        tick();
        tick();
        check("held_look_req", int'(look_req), 1);
        check("held_busy", int'(busy), 1);
        check("pre_reset_line_nonzero", int'(line_adr != 0), 1);
        crobar = 1'b1;
        tick();
        crobar = 1'b0;
        check_all_zero("look_reset");

        // Restart sweeps from line 0, then abort in LOOK
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_look_req", int'(look_req), 1);
        check("restart_line", int'(line_adr), 0);
        check("restart_way", int'(way), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("look_abort_busy", int'(busy), 0);
        check("look_abort_look_req", int'(look_req), 0);
        tick();
        tick();
        check("look_abort_no_done", done_cnt, 0);
        look_en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
